// File: rtl/bcd_step_source.sv
// bcd_step_source: clocked single-digit BCD source that steps up/down at a prescaled rate,
// with parallel load, wrap/saturate at 0 and 9, and a sticky illegal-load flag.
module bcd_step_source #(
    parameter int PRESCALE = 4,
    parameter bit WRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] din,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       step,
    output logic       tc,
    output logic       err
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      q_q, q_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic            step_q, step_d, tc_q, tc_d, err_q, err_d, dir_q, dir_d;
    logic            ld_ok, cnt, fire, at_edge, blocked;
    logic [3:0]      q_next;

    // HOLD only counts again once the direction turns away from the blocked boundary
    always_comb begin
        ld_ok   = load && din <= 4'd9;
        cnt     = en && (state_q != HOLD || up != dir_q);
        fire    = !load && cnt && pc_q == PC_MAX;
        at_edge = up ? q_q == 4'd9 : q_q == 4'd0;
        blocked = fire && at_edge && !WRAP;
        q_next  = up ? (q_q == 4'd9 ? 4'd0 : q_q + 4'd1) : (q_q == 4'd0 ? 4'd9 : q_q - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = load ? ((ld_ok && state_q == HOLD) ? RUN : state_q)
                : !en ? IDLE
                : blocked ? HOLD
                : (state_q == HOLD && up == dir_q) ? HOLD : RUN;
    end

    always_comb begin
        q_d    = ld_ok ? din : (fire && !blocked) ? q_next : q_q;
        pc_d   = (load || !cnt || fire) ? '0 : pc_q + PW'(1);
        step_d = ld_ok || (fire && !blocked);
        tc_d   = fire && at_edge;
        err_d  = err_q || (load && !ld_ok);
        dir_d  = blocked ? up : dir_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            pc_q   <= '0;
            step_q <= 1'b0;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            pc_q   <= pc_d;
            step_q <= step_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
            dir_q  <= dir_d;
        end
    end

    assign {a, b, c, d} = q_q;
    assign step = step_q;
    assign tc   = tc_q;
    assign err  = err_q;
endmodule

// File: tb/tb_bcd_step_source.sv
// tb_bcd_step_source: scoreboard bench for a wrapping and a saturating bcd_step_source.
module tb_bcd_step_source;
    typedef struct {
        int         t;
        logic [3:0] v;
        logic       s;
        logic       tc;
    } exp_t;

    logic clk = 0, rst = 1;
    logic en = 0, up = 0, load = 0;
    logic [3:0] din = 0;
    logic a, b, c, d, step, tc, err;
    logic en_s = 0, up_s = 0, load_s = 0;
    logic [3:0] din_s = 0;
    logic as, bs, cs, ds, step_s, tc_s, err_s;
    int cyc = 0, total = 0, bad = 0;
    exp_t qw[$], qs[$];

    bcd_step_source #(.PRESCALE(4), .WRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .a(a), .b(b), .c(c), .d(d), .step(step), .tc(tc), .err(err));

    bcd_step_source #(.PRESCALE(4), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .up(up_s), .load(load_s), .din(din_s),
        .a(as), .b(bs), .c(cs), .d(ds), .step(step_s), .tc(tc_s), .err(err_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_w(input int t, input int v, input logic s, input logic tcv);
        exp_t e;
        e.t = t; e.v = 4'(v); e.s = s; e.tc = tcv;
        qw.push_back(e);
    endtask

    task automatic push_s(input int t, input int v, input logic s, input logic tcv);
        exp_t e;
        e.t = t; e.v = 4'(v); e.s = s; e.tc = tcv;
        qs.push_back(e);
    endtask

    // Monitors: every step/tc pulse must match the next queued expectation exactly
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (step || tc)) begin
            total++;
            if (qw.size() == 0) begin
                bad++;
                $display("FAIL wrap_unexpected: t=%0d v=%0d step=%0b tc=%0b", cyc, {a, b, c, d}, step, tc);
            end else begin
                e = qw.pop_front();
                if (e.t != cyc || e.v != {a, b, c, d} || e.s != step || e.tc != tc) begin
                    bad++;
                    $display("FAIL wrap_out: got t=%0d v=%0d step=%0b tc=%0b expected t=%0d v=%0d step=%0b tc=%0b",
                             cyc, {a, b, c, d}, step, tc, e.t, e.v, e.s, e.tc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (step_s || tc_s)) begin
            total++;
            if (qs.size() == 0) begin
                bad++;
                $display("FAIL sat_unexpected: t=%0d v=%0d step=%0b tc=%0b", cyc, {as, bs, cs, ds}, step_s, tc_s);
            end else begin
                e = qs.pop_front();
                if (e.t != cyc || e.v != {as, bs, cs, ds} || e.s != step_s || e.tc != tc_s) begin
                    bad++;
                    $display("FAIL sat_out: got t=%0d v=%0d step=%0b tc=%0b expected t=%0d v=%0d step=%0b tc=%0b",
                             cyc, {as, bs, cs, ds}, step_s, tc_s, e.t, e.v, e.s, e.tc);
                end
            end
        end
    end

    initial begin
        int n;
        tick(2);
        rst = 0;
        check("reset_q", {a, b, c, d}, 0);
        check("reset_step", step, 0);
        check("reset_tc", tc, 0);
        check("reset_err", err, 0);

        // Up-count with wrap: 1..9 then 0 with tc
        n = cyc;
        for (int k = 1; k <= 10; k++) push_w(n + 4 * k, k % 10, 1'b1, k == 10);
        en = 1; up = 1;
        tick(40);
        en = 0;
        tick();

        // Load 7 then count down through 0 to 9
        push_w(cyc + 1, 7, 1'b1, 1'b0);
        load = 1; din = 7;
        tick();
        load = 0;
        n = cyc;
        for (int k = 1; k <= 8; k++) push_w(n + 4 * k, (17 - k) % 10, 1'b1, k == 8);
        en = 1; up = 0;
        tick(32);
        en = 0;
        tick();

        // Illegal load leaves q alone and sets sticky err
        push_w(cyc + 1, 3, 1'b1, 1'b0);
        load = 1; din = 3;
        tick();
        din = 12;
        tick();
        load = 0;
        tick(2);
        check("bad_load_q", {a, b, c, d}, 3);
        check("bad_load_err", err, 1);

        // Load on the step edge wins and restarts the prescaler
        n = cyc;
        push_w(n + 4, 4, 1'b1, 1'b0);
        push_w(n + 8, 2, 1'b1, 1'b0);
        push_w(n + 12, 3, 1'b1, 1'b0);
        en = 1; up = 1;
        tick(7);
        load = 1; din = 2;
        tick();
        load = 0;
        tick(4);
        check("load_step_q", {a, b, c, d}, 3);
        check("err_sticky", err, 1);
        en = 0;
        tick();

        // Reset on an edge that would have stepped
        push_w(cyc + 1, 5, 1'b1, 1'b0);
        load = 1; din = 5;
        tick();
        load = 0;
        en = 1;
        tick(3);
        rst = 1;
        tick();
        rst = 0;
        check("midrst_q", {a, b, c, d}, 0);
        check("midrst_step", step, 0);
        check("midrst_tc", tc, 0);
        check("midrst_err", err, 0);
        n = cyc;
        push_w(n + 4, 1, 1'b1, 1'b0);
        tick(4);
        en = 0;
        tick();

        // Saturate: 8 -> 9, blocked step pulses tc alone, reverse leaves HOLD
        push_s(cyc + 1, 8, 1'b1, 1'b0);
        load_s = 1; din_s = 8;
        tick();
        load_s = 0;
        n = cyc;
        push_s(n + 4, 9, 1'b1, 1'b0);
        push_s(n + 8, 9, 1'b0, 1'b1);
        en_s = 1; up_s = 1;
        tick(12);
        check("sat_hold_q", {as, bs, cs, ds}, 9);
        n = cyc;
        push_s(n + 4, 8, 1'b1, 1'b0);
        up_s = 0;
        tick(4);
        check("sat_rev_q", {as, bs, cs, ds}, 8);
        en_s = 0;
        tick(2);

        check("wrap_queue_left", qw.size(), 0);
        check("sat_queue_left", qs.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_step_source.md
# bcd_step_source

Synchronous BCD stimulus source feeding `code_converter` directly. Produces a single BCD digit on `a`,`b`,`c`,`d` (`a` = MSB) that steps up or down at a programmable rate. It supports parallel load, wrap or saturate at the digit boundaries, and flags out-of-range loads. This replaces free-running toggle stimulus with a clocked, controllable, in-range code stream for the converter.

## Interface
Parameters:
- `PRESCALE`, default 4: clock cycles per step while running; legal range 1..255.
- `WRAP`, default 1: 1 = wrap 9↔0; 0 = saturate at 9 (up) or 0 (down).

Ports:
- `clk`, input, 1 bit: sole clock, rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high.
- `en`, input, 1 bit: run enable; the digit steps only while high.
- `up`, input, 1 bit: direction; 1 = increment, 0 = decrement. Sampled at the step edge.
- `load`, input, 1 bit: parallel load strobe.
- `din`, input, 4 bits: load value; legal 0..9.
- `a`, output, 1 bit: BCD bit 3 (MSB); registered.
- `b`, output, 1 bit: BCD bit 2; registered.
- `c`, output, 1 bit: BCD bit 1; registered.
- `d`, output, 1 bit: BCD bit 0 (LSB); registered.
- `step`, output, 1 bit: one-cycle pulse in the cycle a new digit first appears on `a..d`, whether from a count step or a load.
- `tc`, output, 1 bit: one-cycle pulse with `step` on a boundary crossing: 9→0 when counting up, 0→9 when counting down, or a blocked step in saturate mode.
- `err`, output, 1 bit: sticky flag for an illegal load (`din` > 9). Cleared only by `rst`.

## Operation
- Internal state: 4-bit digit `q` driving `{a,b,c,d}`; prescaler count `pc` of width ceil(log2(PRESCALE)), minimum 1 bit; FSM states IDLE, RUN, HOLD.
- Reset, while `rst` is high at a rising edge: `q` = 0, `pc` = 0, `step` = `tc` = `err` = 0, state = IDLE. Reset overrides everything, including a load or step in progress.
- Priority at each edge: `rst` > `load` > count step.
- Load:
  - `din` ≤ 9: `q` ← `din`, `pc` ← 0, `step` = 1 next cycle, `tc` = 0.
  - `din` > 9: `q` unchanged, `err` ← 1, no `step`, `pc` ← 0.
  - A load does not change the FSM state, except that it leaves HOLD (see below).
- FSM transitions:
  - IDLE → RUN when `en` = 1. `pc` counts from 0.
  - RUN → IDLE when `en` = 0. `pc` resets to 0, so a partial prescale is discarded.
  - RUN step: when `pc` = PRESCALE−1 and `en` = 1, `pc` ← 0 and `q` moves one place in direction `up`.
  - WRAP=1: 9+1 → 0 and 0−1 → 9, each with `tc` = 1.
  - WRAP=0: a step that would cross a boundary leaves `q` unchanged, pulses `tc` without `step`, and enters HOLD.
  - HOLD: no counting. Exit to RUN on a valid load, or on `up` reversing relative to the blocked direction (first step follows a full prescale). Exit to IDLE on `en` = 0.
- Invariant: `q` ≤ 9 at all times. Illegal codes 10..15 never reach `code_converter`.
- PRESCALE = 1: steps on every cycle while `en` = 1.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latencies:
  - Load: `din` sampled at edge N; `a..d` and `step` valid after edge N.
  - Count: the first step occurs PRESCALE edges after `en` rises (the edge sampling `en` = 1 is edge 1), then every PRESCALE edges.
  - `step` and `tc` are high for exactly one cycle.
- Load coinciding with a step edge: the load wins, the step is dropped, and `pc` restarts.
- `up` changing mid-prescale takes effect at the next step. `pc` is not reset.
- Reset mid-run: outputs read 0 in the cycle after the reset edge, and no `step` pulse is emitted for that transition.

## Test plan
- Reset, then `en`=1, `up`=1, PRESCALE=4, WRAP=1 → `a..d` = 1,2,…,9,0 at edges 4,8,…,40; `tc` pulses only with 9→0; `step` pulses 10 times.
- `load`=1, `din`=7, then `up`=0 run → 7 appears the cycle after load with `step`; then 6,5,…,0,9; `tc` pulses on 0→9.
- `load` with `din`=12 while `q`=3 → `q` stays 3, `err`=1 and stays 1 until `rst`; no `step`.
- WRAP=0, load 8, `up`=1 → 9, then `tc` pulse with no `step`, state HOLD, `q` holds 9; set `up`=0 → after PRESCALE cycles `q`=8.
- `load` asserted on the same edge `pc` = PRESCALE−1 → loaded value wins, no extra step, next step PRESCALE cycles later.
- `rst` mid-run at `q`=5 with `en`=1 → next cycle `a..d`=0000, `step`=`tc`=`err`=0; after `rst` drops, counting restarts from 0 with a full prescale.
